// File: rtl/seq_serializer_pkg.sv
// Shared definitions for the parallel-to-serial front end of the sequence detector.
// Holds the serializer state encoding and the default word width.
package seq_serializer_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/seq_shift_reg.sv
// Loadable shift register whose output tap follows the configured bit order.
// A load takes priority over a shift in the same cycle.
module seq_shift_reg
    import seq_serializer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_data,
    output logic             out_bit
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = load_data;
        end else if (shift) begin
            sr_d = MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        sr_q <= sr_d;
    end

    assign out_bit = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];

endmodule

// File: rtl/seq_serializer.sv
// Parallel-to-serial converter feeding the sequence detector: one shift register plus a
// holding register so back-to-back words stream without gaps.
//
// state    | meaning
// ST_IDLE  | shift register empty, idle bit driven, ready for a word
// ST_SHIFT | shift register full, one payload bit per cycle
module seq_serializer
    import seq_serializer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             data,
    output logic             data_valid,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hr_q, hr_d;
    logic             hr_full_q, hr_full_d;

    logic             sr_load;
    logic             sr_shift;
    logic [WIDTH-1:0] sr_load_data;
    logic             sr_bit;
    logic             accept;
    logic             last_bit;

    seq_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_sr (
        .clk       (clk),
        .load      (sr_load),
        .shift     (sr_shift),
        .load_data (sr_load_data),
        .out_bit   (sr_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hr_full_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hr_full_q <= hr_full_d;
            hr_q      <= hr_d;
        end
    end

    assign accept   = in_valid && in_ready;
    assign last_bit = (state_q == ST_SHIFT) && (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hr_d         = hr_q;
        hr_full_d    = hr_full_q;
        sr_load      = 1'b0;
        sr_shift     = 1'b0;
        sr_load_data = in_data;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    sr_load = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sr_shift = 1'b1;
                cnt_d    = cnt_q + CW'(1);
                if (last_bit) begin
                    cnt_d = '0;
                    // A waiting or arriving word reloads the register so the stream stays gapless.
                    if (hr_full_q) begin
                        sr_load      = 1'b1;
                        sr_load_data = hr_q;
                        hr_full_d    = 1'b0;
                    end else if (accept) begin
                        sr_load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (accept) begin
                    hr_d      = in_data;
                    hr_full_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready   = !rst && ((state_q == ST_IDLE) || !hr_full_q);
        data       = IDLE_BIT;
        data_valid = 1'b0;
        if (state_q == ST_SHIFT) begin
            data       = sr_bit;
            data_valid = 1'b1;
        end
        busy = (state_q == ST_SHIFT) || hr_full_q;
    end

endmodule

// File: tb/tb_seq_serializer.sv
// Bench for seq_serializer: a bit-queue model predicts every output each cycle for an
// MSB-first and an LSB-first instance, plus literal checks of the expected bit streams.
module tb_seq_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;

    logic in_ready_m, data_m, dv_m, busy_m;
    logic in_ready_l, data_l, dv_l, busy_l;

    seq_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_m), .data(data_m), .data_valid(dv_m), .busy(busy_m)
    );

    seq_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_l), .data(data_l), .data_valid(dv_l), .busy(busy_l)
    );

    always #5 clk = ~clk;

    // Bits still owed on the serial line, front = bit on the wire this cycle.
    bit exp_m[$];
    bit exp_l[$];
    // Payload bits actually observed from each instance.
    bit cap_m[$];
    bit cap_l[$];

    int vectors     = 0;
    int miscompares = 0;

    function automatic int words_pending();
        return (exp_m.size() + W - 1) / W;
    endfunction

    function automatic bit model_ready();
        return !rst && (words_pending() < 2);
    endfunction

    task automatic check1(input string name, input logic act, input logic req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    always @(posedge clk) begin : model
        bit rdy;
        rdy = model_ready();
        if (rst) begin
            exp_m.delete();
            exp_l.delete();
        end else begin
            if (exp_m.size() > 0) begin
                void'(exp_m.pop_front());
                void'(exp_l.pop_front());
            end
            if (in_valid && rdy) begin
                for (int i = 0; i < W; i++) begin
                    exp_m.push_back(in_data[W-1-i]);
                    exp_l.push_back(in_data[i]);
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        bit have;
        have = exp_m.size() > 0;
        check1("in_ready_msb", in_ready_m, model_ready());
        check1("in_ready_lsb", in_ready_l, model_ready());
        check1("data_valid_msb", dv_m, have);
        check1("data_valid_lsb", dv_l, have);
        check1("busy_msb", busy_m, have);
        check1("busy_lsb", busy_l, have);
        check1("data_msb", data_m, have ? exp_m[0] : 1'b0);
        check1("data_lsb", data_l, have ? exp_l[0] : 1'b0);
        if (dv_m === 1'b1) cap_m.push_back(data_m);
        if (dv_l === 1'b1) cap_l.push_back(data_l);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pack_m(input int start);
        logic [7:0] v = '0;
        for (int i = 0; i < 8; i++)
            if (start + i < cap_m.size()) v = {v[6:0], cap_m[start+i]};
        return v;
    endfunction

    function automatic logic [7:0] pack_l(input int start);
        logic [7:0] v = '0;
        for (int i = 0; i < 8; i++)
            if (start + i < cap_l.size()) v = {v[6:0], cap_l[start+i]};
        return v;
    endfunction

    logic [7:0] feed_q[$];

    // Producer holding in_valid high; returns the length of the first data_valid run.
    task automatic feed(output int run);
        int idx;
        bit acc;
        idx = 0;
        run = 0;
        for (int c = 0; c < 80; c++) begin
            if (idx < feed_q.size()) begin
                in_data  = feed_q[idx];
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
                in_data  = 8'h5C;
            end
            acc = in_valid && in_ready_m;
            step(1);
            if (acc) idx++;
            if (dv_m === 1'b1) run++;
            else if (run > 0) break;
        end
        in_valid = 1'b0;
        check_int("feed_words_accepted", idx, feed_q.size());
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : main
        int mark;
        int run;
        int hits;
        int golden;
        logic [15:0] cat;

        rst = 1'b1;
        step(3);
        check1("in_ready_in_reset", in_ready_m, 1'b0);
        rst = 1'b0;
        step(2);
        check1("idle_in_ready", in_ready_m, 1'b1);
        check1("idle_data_valid", dv_m, 1'b0);
        check1("idle_busy", busy_m, 1'b0);

        // Single word 8'hB5
        mark = cap_m.size();
        in_data = 8'hB5; in_valid = 1'b1;
        step(1);
        in_valid = 1'b0; in_data = 8'h3E;
        step(10);
        check_int("single_len", cap_m.size() - mark, 8);
        check_int("single_msb_bits", int'(pack_m(mark)), int'(8'hB5));
        check_int("single_lsb_bits", int'(pack_l(mark)), int'(8'hAD));

        // Back-to-back FF, 00, A5
        mark = cap_m.size();
        feed_q = '{8'hFF, 8'h00, 8'hA5};
        feed(run);
        step(4);
        check_int("b2b_run_length", run, 24);
        check_int("b2b_word0", int'(pack_m(mark)), int'(8'hFF));
        check_int("b2b_word1", int'(pack_m(mark + 8)), int'(8'h00));
        check_int("b2b_word2", int'(pack_m(mark + 16)), int'(8'hA5));
        check_int("b2b_lsb_word2", int'(pack_l(mark + 16)), int'(8'hA5));

        // Bypass: second word offered exactly on the last-bit cycle
        mark = cap_m.size();
        in_data = 8'h5A; in_valid = 1'b1;
        step(1);
        in_valid = 1'b0;
        step(7);
        check1("bypass_ready_last_bit", in_ready_m, 1'b1);
        check1("bypass_last_bit_valid", dv_m, 1'b1);
        in_data = 8'hC6; in_valid = 1'b1;
        step(1);
        in_valid = 1'b0;
        check1("bypass_no_gap", dv_m, 1'b1);
        step(12);
        check_int("bypass_len", cap_m.size() - mark, 16);
        check_int("bypass_word0", int'(pack_m(mark)), int'(8'h5A));
        check_int("bypass_word1", int'(pack_m(mark + 8)), int'(8'hC6));

        // Reset on the 4th bit of C3 with 3C waiting
        in_data = 8'hC3; in_valid = 1'b1;
        step(1);
        in_data = 8'h3C;
        check1("rst_hr_ready", in_ready_m, 1'b1);
        step(1);
        in_valid = 1'b0;
        step(2);
        rst = 1'b1;
        #1;
        check1("rst_ready_low", in_ready_m, 1'b0);
        step(1);
        check1("rst_dv_cleared", dv_m, 1'b0);
        check1("rst_busy_cleared", busy_m, 1'b0);
        rst = 1'b0;
        mark = cap_m.size();
        step(20);
        check_int("rst_no_resume", cap_m.size() - mark, 0);
        check1("rst_ready_after", in_ready_m, 1'b1);

        // Downstream pairing: count overlapping 1010 matches over 0A, A0
        mark = cap_m.size();
        feed_q = '{8'h0A, 8'hA0};
        feed(run);
        step(4);
        check_int("det_run_length", run, 16);
        hits = 0;
        for (int i = mark; i + 3 < cap_m.size(); i++)
            if (cap_m[i] && !cap_m[i+1] && cap_m[i+2] && !cap_m[i+3]) hits++;
        cat = {8'h0A, 8'hA0};
        golden = 0;
        for (int i = 15; i >= 3; i--)
            if (cat[i -: 4] == 4'b1010) golden++;
        check_int("det_golden_literal", golden, 3);
        check_int("det_pulses", hits, golden);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
